// File: rtl/shift_unit_mc_if.sv
// Start/busy/done handshake bundle between the multicycle control FSM and
// the shift unit.
//   master : control side  - drives start, op, data_in, shamt; sees busy, done, result
//   slave  : shift unit    - sees start, op, data_in, shamt; drives busy, done, result
interface shift_unit_mc_if #(
    parameter int unsigned Bits = 32
);
    localparam int unsigned SHAMT_W = $clog2(Bits);

    logic               start;
    logic [2:0]         op;
    logic [Bits-1:0]    data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [Bits-1:0]    result;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/shift_unit_mc.sv
// Multi-cycle shift unit (SLL/SRL/SRA/ROTR/LUI) for the MIPS datapath.
// Moves at most STEP bit positions per clock so the per-cycle shifter is only
// STEP positions deep; a start/busy/done handshake paces the control FSM.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, returns to IDLE and clears result
//   bus  : slave side of shift_unit_mc_if
//          start/op/data_in/shamt in, busy/done/result out (all registered)
module shift_unit_mc #(
    parameter int unsigned Bits = 32,
    parameter int unsigned STEP = 4
) (
    input  logic           clk,
    input  logic           rst,
    shift_unit_mc_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(Bits);
    // One extra bit so STEP == Bits is representable in the step compare.
    localparam int unsigned CNT_W   = SHAMT_W + 1;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROTR = 3'b011;
    localparam logic [2:0] OP_LUI  = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [Bits-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [2:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic               busy_q, done_q;

    logic [SHAMT_W-1:0] start_amt;
    logic [CNT_W-1:0]   rem_ext;
    logic [CNT_W-1:0]   step;
    logic [SHAMT_W-1:0] rem_nx;
    logic [Bits-1:0]    acc_sh;
    logic [2*Bits-1:0]  wide;

    // Shift amount requested by the incoming op; reserved ops pass through.
    always_comb begin
        start_amt = '0;
        case (bus.op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROTR: start_amt = bus.shamt;
            OP_LUI:                          start_amt = SHAMT_W'(Bits / 2);
            default:                         start_amt = '0;
        endcase
    end

    // Positions moved this cycle: min(rem, STEP), and what is left afterwards.
    always_comb begin
        rem_ext = CNT_W'(rem_q);
        step    = (rem_ext < CNT_W'(STEP)) ? rem_ext : CNT_W'(STEP);
        rem_nx  = SHAMT_W'(rem_ext - step);
    end

    // One partial shift of the accumulator. Right shifts go through a
    // double-width word whose upper half supplies the fill bits.
    always_comb begin
        wide   = '0;
        acc_sh = acc_q;
        case (op_q)
            OP_SLL, OP_LUI: acc_sh = acc_q << step;
            OP_SRL:         acc_sh = acc_q >> step;
            OP_SRA: begin
                wide   = {{Bits{sign_q}}, acc_q} >> step;
                acc_sh = wide[Bits-1:0];
            end
            OP_ROTR: begin
                wide   = {acc_q, acc_q} >> step;
                acc_sh = wide[Bits-1:0];
            end
            default:        acc_sh = acc_q;
        endcase
    end

    // Next-state logic; IDLE and DONE both accept, giving back-to-back ops.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    acc_d   = bus.data_in;
                    sign_d  = bus.data_in[Bits-1];
                    rem_d   = start_amt;
                    state_d = (start_amt == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = acc_sh;
                rem_d = rem_nx;
                if (rem_nx == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; busy/done are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = acc_q;

endmodule
